// File: rtl/shift_seq_arb.sv
// rtl/shift_seq_arb.sv - two-requester arbiter sequencing a bidirectional shift register
//
// Optional feature macro: SHIFT_SEQ_RR_EN
//   defined   : round-robin arbitration (the requester not served last wins a tie)
//   undefined : fixed priority, req0 always wins; no last-served pointer exists
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous active-high reset
//   req0/req1      transfer requests, held until the matching done pulse
//   dir0/dir1      shift direction per requester (1 = right, 0 = left)
//   len0/len1      requested shift cycles (saturated at WIDTH)
//   din0/din1      serial bits, bit i goes out on shift cycle i
//   gnt0/gnt1      ownership of the shift register (one-hot or zero)
//   done0/done1    one-cycle completion pulse to the owner
//   sh_en          shift enable
//   sh_right       direction select (holds its value outside shifting)
//   sh_d           serial data bit
//   busy           high whenever the sequencer is not idle
module shift_seq_arb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             sh_en,
    output logic             sh_right,
    output logic             sh_d,
    output logic             busy
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, GRANT, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic             owner;       // 1 = requester 1 owns the register
    logic             dir_q;
    logic [WIDTH-1:0] din_q;       // shifted down each SHIFT cycle, bit 0 is next out
    logic [CNT_W-1:0] len_q;       // effective (saturated) length
    logic [CNT_W-1:0] cnt;
    logic             sh_right_q;
    logic             pick;        // requester selected this IDLE cycle
    logic [CNT_W-1:0] len_sel;
    logic [CNT_W-1:0] len_eff;

`ifdef SHIFT_SEQ_RR_EN
    logic last;                    // requester served most recently

    // Tie goes to whoever was not served last; a lone request always wins.
    assign pick = req1 & (~req0 | ~last);

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (state == IDLE && (req0 || req1)) begin
            last <= pick;
        end
    end
`else
    assign pick = ~req0;
`endif

    assign len_sel = pick ? len1 : len0;
    assign len_eff = (len_sel > WIDTH_C) ? WIDTH_C : len_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req0 || req1) state_nx = GRANT;
            GRANT: state_nx = (len_q != '0) ? SHIFT : DONE;
            SHIFT: if (cnt == len_q - ONE_C) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Every output is a function of registered state only, so nothing moves
    // except on the rising edge.
    always_comb begin
        busy     = (state != IDLE);
        gnt0     = busy & ~owner;
        gnt1     = busy & owner;
        done0    = (state == DONE) & ~owner;
        done1    = (state == DONE) & owner;
        sh_en    = (state == SHIFT);
        sh_d     = sh_en & din_q[0];
        sh_right = sh_right_q;
    end

    // Owner fields are captured on the edge that enters GRANT, so they are
    // already stable throughout the GRANT cycle; later req changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            dir_q      <= 1'b0;
            din_q      <= '0;
            len_q      <= '0;
            cnt        <= '0;
            sh_right_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick;
                        dir_q <= pick ? dir1 : dir0;
                        din_q <= pick ? din1 : din0;
                        len_q <= len_eff;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    // Direction only changes when a shift actually happens.
                    if (len_q != '0) sh_right_q <= dir_q;
                end
                SHIFT: begin
                    cnt   <= cnt + ONE_C;
                    din_q <= din_q >> 1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_seq_arb.md
SHIFT_SEQ_ARB -- requirements
Module: shift_seq_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit length of the bidirectional shift register being driven.
REQ-002 SHALL have parameter CNT_W, default 3: width of the length fields; 2**CNT_W > WIDTH.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1  transfer request per requester; held until matching done pulse.
REQ-006 SHALL have ports dir0/dir1  input  1  direction; 1 = shift right, 0 = shift left.
REQ-007 SHALL have ports len0/len1  input  CNT_W  number of shift cycles requested.
REQ-008 SHALL have ports din0/din1  input  WIDTH  serial bits to insert; bit i is inserted on shift cycle i.
REQ-009 SHALL have ports gnt0/gnt1  output  1  ownership of the shift register, one-hot or zero.
REQ-010 SHALL have ports done0/done1  output  1  one-cycle completion pulse to the owner.
REQ-011 SHALL have port sh_en  output  1  shift enable to the register.
REQ-012 SHALL have port sh_right  output  1  direction select to the register.
REQ-013 SHALL have port sh_d  output  1  serial data bit to the register.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, SHIFT, DONE.
REQ-016 IDLE: on any req high, go to GRANT and select the owner per REQ-023/REQ-031; otherwise stay in IDLE.
REQ-017 GRANT, one cycle: assert the owner's gnt; latch dir, len, din of the owner; clear the bit counter to 0.
REQ-018 GRANT exit: go to SHIFT if the effective length is nonzero, else go directly to DONE.
REQ-019 Effective length SHALL be min(len, WIDTH); values above WIDTH saturate.
REQ-020 SHIFT: sh_en=1, sh_right=latched dir, sh_d=latched din[counter]; counter increments each cycle; exit to DONE when counter reaches effective length minus 1.
REQ-021 DONE, one cycle: pulse the owner's done; sh_en=0; gnt stays high this cycle; then go to IDLE.
REQ-022 Outputs SHALL change only on the rising edge, so they are stable at the register's falling-edge sample point.
REQ-023 Arbitration: when both req are high in IDLE, the requester not served last wins.
REQ-024 Deasserting req during GRANT/SHIFT/DONE SHALL be ignored; the transfer completes.
REQ-025 Requests arriving while busy SHALL wait; they are evaluated on the next IDLE cycle.
REQ-026 Outside SHIFT: sh_en=0, sh_d=0; sh_right holds its last value.
REQ-027 gnt0 and gnt1 SHALL never be high together.

Reset
REQ-028 On rst: state=IDLE; counter=0; gnt0/gnt1, done0/done1, sh_en, sh_right, sh_d, busy=0; last-served pointer=requester 1, so requester 0 wins first.
REQ-029 rst mid-transfer SHALL abort with no done pulse; outputs are at reset values in the cycle after rst is sampled.
REQ-030 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-031 Macro SHIFT_SEQ_RR_EN: when defined, arbitration is round-robin per REQ-023; when undefined, priority is fixed with req0 always winning and no last-served pointer is implemented.

Verification
REQ-032 rst, then req0=1, dir0=1, len0=4, din0=4'b1011 -> GRANT at cycle 1; sh_en high for cycles 2-5 with sh_d 1,1,0,1; done0 at cycle 6; busy low at cycle 7.
REQ-033 req0 and req1 both high in IDLE, both held (RR enabled) -> requester 0 served, then 1, then 0; each done pulse is one cycle; gnt never overlaps.
REQ-034 req1=1, len1=0 -> GRANT then DONE directly; sh_en never asserted; done1 two cycles after request.
REQ-035 len0=7 with WIDTH=4 -> exactly 4 sh_en cycles.
REQ-036 rst asserted in the second SHIFT cycle -> next cycle all outputs 0, state IDLE, no done pulse; a following req0 is served normally.
REQ-037 With SHIFT_SEQ_RR_EN undefined, req0 and req1 held continuously -> requester 0 granted every time and requester 1 never granted.
